// File: rtl/instr_encoder_pkg.sv
// +----------------------------------------------------------------------+
// | instr_encoder_pkg : opcodes, NOP word and FSM encoding (rev 1.0)     |
// +----------------------------------------------------------------------+
`default_nettype none

package instr_encoder_pkg;

  localparam logic [6:0]  c_OP_RTYPE      = 7'b0110011;
  localparam logic [6:0]  c_OP_ITYPE      = 7'b0010011;
  localparam logic [6:0]  c_OP_STYPE      = 7'b0100011;
  localparam logic [6:0]  c_OP_BTYPE      = 7'b1100011;
  localparam logic [6:0]  c_OP_UTYPE_LUI  = 7'b0110111;
  localparam logic [6:0]  c_OP_UTYPE_AUIPC = 7'b0010111;
  localparam logic [6:0]  c_OP_UJTYPE     = 7'b1101111;

  localparam logic [31:0] c_NOP       = 32'h0000_0013;
  localparam logic [31:0] c_ADDR_STEP = 32'd4;
  localparam logic [15:0] c_COUNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  typedef struct packed {
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [6:0] opcode;
  } opfields_t;

endpackage

`default_nettype wire

// File: rtl/instr_encoder_if.sv
// +----------------------------------------------------------------------+
// | instr_encoder_if : field-bundle input and encoded-word output (1.0)  |
// +----------------------------------------------------------------------+
`default_nettype none

interface instr_encoder_if;

  logic        in_valid;
  logic        in_ready;
  logic [16:0] in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_illegal;

  // The encoder itself: consumes field bundles, produces words.
  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_illegal
  );

  // The decoder/memory-writer side surrounding the encoder.
  modport master (
    output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_illegal
  );

endinterface

`default_nettype wire

// File: rtl/instr_pack.sv
// +----------------------------------------------------------------------+
// | instr_pack : combinational RV32I field packer with illegal flag (1.0)|
// +----------------------------------------------------------------------+
`default_nettype none

module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [16:0] i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_instr,
  output logic        o_illegal
);

  opfields_t w_f;
  assign w_f = opfields_t'(i_opcode);

  always_comb begin
    o_instr   = c_NOP;
    o_illegal = 1'b0;
    case (w_f.opcode)
      c_OP_RTYPE:
        o_instr = {w_f.funct7, i_rs2, i_rs1, w_f.funct3, i_rd, w_f.opcode};
      // Shift funct7/shamt already sit in imm[11:0], so shifts need no special case.
      c_OP_ITYPE:
        o_instr = {i_imm[11:0], i_rs1, w_f.funct3, i_rd, w_f.opcode};
      c_OP_STYPE:
        o_instr = {i_imm[11:5], i_rs2, i_rs1, w_f.funct3, i_imm[4:0], w_f.opcode};
      c_OP_BTYPE:
        o_instr = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, w_f.funct3,
                   i_imm[4:1], i_imm[11], w_f.opcode};
      c_OP_UTYPE_LUI, c_OP_UTYPE_AUIPC:
        o_instr = {i_imm[31:12], i_rd, w_f.opcode};
      c_OP_UJTYPE:
        o_instr = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, w_f.opcode};
      default: begin
        o_instr   = c_NOP;
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// +----------------------------------------------------------------------+
// | instr_encoder : RV32I word encoder with address/count tracking (1.0) |
// +----------------------------------------------------------------------+
`default_nettype none

module instr_encoder
  import instr_encoder_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [31:0]        i_base_addr,
  input  logic               i_flush,
  output logic               o_busy,
  output logic [15:0]        o_instr_count,
  instr_encoder_if.slave     bus
);

  state_t      r_state;
  logic        r_out_valid;
  logic [31:0] r_out_instr;
  logic [31:0] r_out_addr;
  logic        r_out_illegal;
  logic [31:0] r_addr;
  logic [15:0] r_count;

  logic [31:0] w_pack_instr;
  logic        w_pack_illegal;
  logic        w_in_ready;
  logic        w_in_fire;
  logic        w_out_fire;

  instr_pack u_pack (
    .i_opcode  (bus.in_opcode),
    .i_rd      (bus.in_rd),
    .i_rs1     (bus.in_rs1),
    .i_rs2     (bus.in_rs2),
    .i_imm     (bus.in_imm),
    .o_instr   (w_pack_instr),
    .o_illegal (w_pack_illegal)
  );

  assign w_in_ready = (r_state == S_ACTIVE) && (!r_out_valid || bus.out_ready);
  assign w_in_fire  = bus.in_valid && w_in_ready;
  assign w_out_fire = r_out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_out_valid   <= 1'b0;
      r_out_instr   <= 32'd0;
      r_out_addr    <= 32'd0;
      r_out_illegal <= 1'b0;
      r_addr        <= 32'd0;
      r_count       <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE:   if (i_start) r_state <= S_ACTIVE;
        S_ACTIVE: if (i_flush) r_state <= S_DRAIN;
        S_DRAIN:  if (!r_out_valid || w_out_fire) r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase

      // A new word may replace one leaving in the same cycle.
      if (w_in_fire) begin
        r_out_valid   <= 1'b1;
        r_out_instr   <= w_pack_instr;
        r_out_addr    <= r_addr;
        r_out_illegal <= w_pack_illegal;
      end else if (w_out_fire) begin
        r_out_valid   <= 1'b0;
      end

      // Nothing can transfer in IDLE, so start never collides with a count/address step.
      if ((r_state == S_IDLE) && i_start) begin
        r_addr  <= i_base_addr;
        r_count <= 16'd0;
      end else begin
        if (w_in_fire) begin
          r_addr <= r_addr + c_ADDR_STEP;
        end
        if (w_out_fire && (r_count != c_COUNT_MAX)) begin
          r_count <= r_count + 16'd1;
        end
      end
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_instr   = r_out_instr;
  assign bus.out_addr    = r_out_addr;
  assign bus.out_illegal = r_out_illegal;
  assign o_busy          = (r_state != S_IDLE);
  assign o_instr_count   = r_count;

endmodule

`default_nettype wire
